// File: rtl/clock_enables_pkg.sv
// Shared constants for the ZX48 clock enable generator.
// Turbo encodings, CPU contention states and pixel phases.
package clock_enables_pkg;

  localparam logic [1:0] TURBO_3M5 = 2'b00;
  localparam logic [1:0] TURBO_7M  = 2'b01;
  localparam logic [1:0] TURBO_14M = 2'b10;

  typedef enum logic {
    RUN,
    HOLD
  } cpu_state_t;

  localparam logic [2:0] PH7_P = 3'd0;
  localparam logic [2:0] PH7_N = 3'd4;

endpackage

// File: rtl/reset_stretch.sv
// Holds the core reset high for RST_CYCLES clocks
// after the generator reset releases.
module reset_stretch #(
  parameter int RST_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  output logic rst_out
);

  localparam int W = $clog2(RST_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(RST_CYCLES);

  logic [W-1:0] rcnt;
  logic         busy;

  assign busy = (rcnt != LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      rcnt <= '0;
    end else if (busy) begin
      rcnt <= rcnt + W'(1);
    end
  end

  assign rst_out = reset | busy;

endmodule

// File: rtl/clock_enables.sv
// 56 MHz phase counter decoding pixel, CPU and PSG
// enables, with turbo select and ULA contention.
module clock_enables
  import clock_enables_pkg::*;
#(
  parameter int RST_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] turbo,
  input  logic       contend,
  output logic       rst_out,
  output logic       pe7,
  output logic       ne7,
  output logic       pe_cpu,
  output logic       ne_cpu,
  output logic       ce_psg,
  output logic       stall
);

  logic [4:0] cnt;
  logic [1:0] turbo_q;
  cpu_state_t state;
  logic       slot_p;
  logic       slot_n;
  logic       run;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      turbo_q <= TURBO_3M5;
      state   <= RUN;
    end else begin
      cnt <= cnt + 5'd1;
      // speed changes only land on a 16-clock boundary
      if (cnt[3:0] == 4'd15) begin
        turbo_q <= turbo;
      end
      if (slot_p) begin
        state <= contend ? HOLD : RUN;
      end
    end
  end

  always_comb begin
    slot_p = 1'b0;
    slot_n = 1'b0;
    unique case (1'b1)
      turbo_q == TURBO_3M5: begin
        slot_p = (cnt[3:0] == 4'd0);
        slot_n = (cnt[3:0] == 4'd8);
      end
      turbo_q == TURBO_7M: begin
        slot_p = (cnt[2:0] == 3'd0);
        slot_n = (cnt[2:0] == 3'd4);
      end
      default: begin
        slot_p = (cnt[1:0] == 2'd0);
        slot_n = (cnt[1:0] == 2'd2);
      end
    endcase
  end

  assign run    = ~reset;
  assign pe7    = run & (cnt[2:0] == PH7_P);
  assign ne7    = run & (cnt[2:0] == PH7_N);
  assign ce_psg = run & (cnt == 5'd0);
  // a held CPU resumes only through a rising slot
  assign pe_cpu = run & slot_p & ~contend;
  assign ne_cpu = run & slot_n & (state == RUN);
  assign stall  = (state == HOLD);

  reset_stretch #(
    .RST_CYCLES(RST_CYCLES)
  ) u_rst (
    .clock  (clock),
    .reset  (reset),
    .rst_out(rst_out)
  );

endmodule

// File: tb/tb_clock_enables.sv
// Directed bench for clock_enables with a short
// reset stretch; phase tracked in ph.
module tb_clock_enables;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] turbo = 2'b00;
  logic       contend = 1'b0;
  logic       rst_out;
  logic       pe7, ne7, pe_cpu, ne_cpu;
  logic       ce_psg, stall;

  int         n_run = 0;
  int         n_fail = 0;
  logic [4:0] ph = '0;

  always #5 clock = ~clock;

  clock_enables #(
    .RST_CYCLES(16)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .turbo  (turbo),
    .contend(contend),
    .rst_out(rst_out),
    .pe7    (pe7),
    .ne7    (ne7),
    .pe_cpu (pe_cpu),
    .ne_cpu (ne_cpu),
    .ce_psg (ce_psg),
    .stall  (stall)
  );

  task automatic adv();
    @(posedge clock);
    #1;
    ph = ph + 5'd1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic go_to(input logic [4:0] p);
    while (ph != p) adv();
  endtask

  function automatic logic [5:0] obs();
    return {pe7, ne7, pe_cpu, ne_cpu, ce_psg, stall};
  endfunction

  // {pe7,ne7,pe_cpu,ne_cpu,ce_psg,stall}, no contention
  function automatic logic [5:0] base(
    input logic [4:0] p,
    input logic [1:0] sp
  );
    logic pc, nc;
    case (sp)
      2'b00: begin
        pc = (p[3:0] == 4'd0);
        nc = (p[3:0] == 4'd8);
      end
      2'b01: begin
        pc = (p[2:0] == 3'd0);
        nc = (p[2:0] == 3'd4);
      end
      default: begin
        pc = (p[1:0] == 2'd0);
        nc = (p[1:0] == 2'd2);
      end
    endcase
    return {p[2:0] == 3'd0, p[2:0] == 3'd4,
            pc, nc, p == 5'd0, 1'b0};
  endfunction

  task automatic test_reset();
    logic [5:0] o;
    logic       r;
    reset = 1'b1;
    turbo = 2'b00;
    contend = 1'b0;
    repeat (5) begin
      smp();
      o = obs();
      n_run++;
      if ({rst_out, o[5:1]} !== 6'b100000) begin
        n_fail++;
        $display("FAIL in_reset got=%b exp=100000",
                 {rst_out, o[5:1]});
      end
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    ph = '0;
    for (int k = 0; k < 20; k++) begin
      smp();
      r = (k < 16);
      n_run++;
      if (rst_out !== r) begin
        n_fail++;
        $display("FAIL rst_stretch k=%0d got=%b exp=%b",
                 k, rst_out, r);
      end
      if (k == 0) begin
        n_run++;
        if ({pe7, ce_psg, pe_cpu} !== 3'b111) begin
          n_fail++;
          $display("FAIL first_cycle got=%b exp=111",
                   {pe7, ce_psg, pe_cpu});
        end
      end
      adv();
    end
  endtask

  task automatic test_base();
    int c_pe7, c_ne7, c_psg, c_pe;
    logic [5:0] e;
    c_pe7 = 0;
    c_ne7 = 0;
    c_psg = 0;
    c_pe = 0;
    go_to(5'd0);
    for (int i = 0; i < 64; i++) begin
      smp();
      e = base(ph, 2'b00);
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL base ph=%0d got=%b exp=%b",
                 ph, obs(), e);
      end
      c_pe7 += int'(pe7);
      c_ne7 += int'(ne7);
      c_psg += int'(ce_psg);
      c_pe += int'(pe_cpu);
      adv();
    end
    n_run++;
    if ({c_pe7, c_ne7, c_psg, c_pe} !== {32'd8, 32'd8, 32'd2, 32'd4}) begin
      n_fail++;
      $display("FAIL base_counts got=%0d/%0d/%0d/%0d exp=8/8/2/4",
               c_pe7, c_ne7, c_psg, c_pe);
    end
  endtask

  task automatic test_turbo();
    logic [5:0] e;
    int last;
    last = -100;
    go_to(5'd0);
    for (int i = 0; i < 48; i++) begin
      if (i == 5) turbo = 2'b10;
      smp();
      e = base(ph, (i < 16) ? 2'b00 : 2'b10);
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL turbo i=%0d got=%b exp=%b",
                 i, obs(), e);
      end
      if (pe_cpu === 1'b1) begin
        n_run++;
        if (i - last < 4) begin
          n_fail++;
          $display("FAIL turbo_gap i=%0d gap=%0d min=4",
                   i, i - last);
        end
        last = i;
      end
      adv();
    end
    turbo = 2'b00;
    go_to(5'd0);
  endtask

  task automatic test_contend();
    logic [5:0] e;
    go_to(5'd0);
    for (int i = 0; i < 64; i++) begin
      contend = (i <= 20);
      smp();
      e = base(ph, 2'b00);
      e[3] = (i % 16 == 0) && (i >= 32);
      e[2] = (i % 16 == 8) && (i >= 40);
      e[0] = (i >= 1) && (i <= 32);
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL contend i=%0d got=%b exp=%b",
                 i, obs(), e);
      end
      adv();
    end
    contend = 1'b0;
  endtask

  task automatic test_nonslot();
    logic [5:0] e;
    go_to(5'd0);
    for (int i = 0; i < 32; i++) begin
      contend = (i == 4);
      smp();
      e = base(ph, 2'b00);
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL nonslot i=%0d got=%b exp=%b",
                 i, obs(), e);
      end
      adv();
    end
    contend = 1'b0;
  endtask

  task automatic test_reset_hold();
    logic [5:0] e;
    logic [5:0] o;
    logic       r;
    turbo = 2'b10;
    go_to(5'd16);
    contend = 1'b1;
    smp();
    n_run++;
    if (obs() !== 6'b100000) begin
      n_fail++;
      $display("FAIL hold_enter got=%b exp=100000", obs());
    end
    adv();
    smp();
    n_run++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_stall got=%b exp=1", stall);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    contend = 1'b0;
    repeat (2) begin
      smp();
      o = obs();
      n_run++;
      if ({rst_out, o[5:1]} !== 6'b100000) begin
        n_fail++;
        $display("FAIL hold_reset got=%b exp=100000",
                 {rst_out, o[5:1]});
      end
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    ph = '0;
    for (int k = 0; k < 17; k++) begin
      smp();
      r = (k < 16);
      n_run++;
      if (rst_out !== r) begin
        n_fail++;
        $display("FAIL rerst k=%0d got=%b exp=%b",
                 k, rst_out, r);
      end
      if (k < 16) begin
        e = base(ph, 2'b00);
        n_run++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL post_reset k=%0d got=%b exp=%b",
                   k, obs(), e);
        end
      end
      adv();
    end
    turbo = 2'b00;
  endtask

  initial begin
    test_reset();
    test_base();
    test_turbo();
    test_contend();
    test_nonslot();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
